program_loader: RTL
===================

Name: program_loader

Overview:
- Writer side of the CPU program-load interface (edit/line/code/send).
- Accepts a byte stream with a valid/ready handshake from a host link (UART/bridge).
- Packs each 4 bytes into a 32-bit instruction word and writes it to the program ROM one line at a time, with a set-up/strobe/hold sequence the edge-sensitive ROM side can latch reliably.
- Sits between the host link and the computer top level; owns the edit signal for the duration of a load.

Parameters:
- LINE_W, 8, width of line address.
- WORD_W, 32, instruction width; must be a multiple of 8.
- SEND_W, 2, cycles send is held high per line (≥1).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle request to begin a load; ignored unless idle.
- num_lines  in  LINE_W  lines to load, sampled on accepted start; 0 means 2^LINE_W.
- abort  in  1  terminate load at the next cycle.
- byte_in  in  8  stream data.
- byte_valid  in  1  stream data valid.
- byte_ready  out  1  loader can accept byte_in.
- edit  out  1  programming-mode enable to the computer.
- line  out  LINE_W  ROM line being written.
- code  out  WORD_W  instruction word being written.
- send  out  1  write strobe.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse, load completed normally.
- aborted  out  1  one-cycle pulse, load terminated by abort.

Behaviour:
- Reset values (asynchronous; also forced to IDLE mid-operation):
  - byte_ready=0, edit=0, line=0, code=0, send=0, busy=0, done=0, aborted=0.
  - Internal byte index=0, line counter=0.
- States: IDLE, COLLECT, SETUP, STROBE, HOLD, FINISH.
- IDLE:
  - start=1 → latch num_lines (0→2^LINE_W), clear line and code, set edit=1 and busy=1, go to COLLECT.
  - start in any other state is ignored.
- COLLECT:
  - byte_ready=1.
  - Byte accepted when byte_valid&&byte_ready.
  - Byte k (k=0..WORD_W/8-1) goes to code[8k+7:8k] (little-endian, first byte = LSB).
  - On the last byte of a word → SETUP. byte_ready drops to 0 the cycle after that acceptance.
  - byte_valid low simply waits; there is no timeout.
- SETUP: one cycle, send=0, line/code stable. Go to STROBE.
- STROBE: send=1 for exactly SEND_W cycles, line/code stable. Go to HOLD.
- HOLD: one cycle, send=0, line/code still stable.
  - If lines written == latched count → FINISH.
  - Otherwise line increments by 1 (wraps 2^LINE_W-1 → 0, only reachable on the final line), byte index clears, go to COLLECT.
- FINISH: one cycle, done=1, edit=0, busy=0 on exit. Return to IDLE; line/code keep their final values.
- Per-line latency: last byte accepted at cycle t → send high at t+2 .. t+1+SEND_W. Next byte_ready at t+3+SEND_W.
- abort:
  - Sampled in any non-IDLE state.
  - Next cycle: send=0, edit=0, busy=0, byte_ready=0, aborted=1 for one cycle, state=IDLE.
  - A partially collected word is discarded; lines already strobed stay written.
- abort and start together in IDLE: start wins, since abort is ignored in IDLE.
- abort during STROBE cuts the strobe short. This is legal; that line is treated as not written.
- edit is high from the cycle after the accepted start through the FINISH cycle inclusive. It never toggles within a load.
- done and aborted are never high together.

Test Plan:
- Single line: num_lines=1, bytes 0x78,0x56,0x34,0x12 back-to-back → line=0, code=0x12345678, send high 2 cycles starting 2 cycles after the 4th byte, then done=1 one cycle, edit=0.
- Three lines with gaps: byte_valid toggling 1-of-3 cycles, words 0x00000001/0x00000002/0x00000003 → three send bursts at line=0,1,2 with matching code; byte_ready=0 during SETUP/STROBE/HOLD; exactly one done.
- Full ROM: num_lines=0 → 256 strobes, line 0..255, no wrap strobe, done after line 255; edit high throughout.
- Abort mid-word: abort after 2 bytes of line 5 → aborted=1, edit=0 next cycle, no strobe for line 5, done never asserts.
- Reset mid-strobe: rst asserted asynchronously while send=1 → send, edit, busy drop immediately, all outputs at reset values; a new start afterwards loads from line 0.
- Start while busy: second start pulse during COLLECT → ignored; latched count unchanged, load completes normally.

Source files
------------

// File: rtl/program_loader_if.sv
// program_loader_if: byte stream, load control and ROM write bus of the program loader
interface program_loader_if #(
  parameter int LINE_W = 8,
  parameter int WORD_W = 32
);
  logic              start;
  logic [LINE_W-1:0] num_lines;
  logic              abort;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              edit;
  logic [LINE_W-1:0] line;
  logic [WORD_W-1:0] code;
  logic              send;
  logic              busy;
  logic              done;
  logic              aborted;
  modport master (
    output start, num_lines, abort, byte_in, byte_valid,
    input  byte_ready, edit, line, code, send, busy, done, aborted
  );
  modport slave (
    input  start, num_lines, abort, byte_in, byte_valid,
    output byte_ready, edit, line, code, send, busy, done, aborted
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: packs a byte stream into words and strobes them into the program ROM line by line
module program_loader #(
  parameter int LINE_W = 8,
  parameter int WORD_W = 32,
  parameter int SEND_W = 2
) (
  input logic clk,
  input logic rst,
  program_loader_if.slave bus
);
  localparam int NB   = WORD_W / 8;
  localparam int BI_W = $clog2(NB) + 1;
  localparam int SC_W = $clog2(SEND_W + 1);
  typedef enum logic [2:0] {IDLE, COLLECT, SETUP, STROBE, HOLD, FINISH} state_t;
  state_t            state;
  logic [LINE_W:0]   total;
  logic [BI_W-1:0]   bidx;
  logic [SC_W-1:0]   scnt;
  logic              byte_ready, edit, send, busy, done, aborted;
  logic [LINE_W-1:0] line;
  logic [WORD_W-1:0] code;
  assign bus.byte_ready = byte_ready;
  assign bus.edit       = edit;
  assign bus.line       = line;
  assign bus.code       = code;
  assign bus.send       = send;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.aborted    = aborted;
  // load sequencer: collect bytes, then setup/strobe/hold each line; abort wins over everything outside IDLE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      total      <= '0;
      bidx       <= '0;
      scnt       <= '0;
      byte_ready <= 1'b0;
      edit       <= 1'b0;
      line       <= '0;
      code       <= '0;
      send       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (state != IDLE && bus.abort) begin
        state      <= IDLE;
        bidx       <= '0;
        byte_ready <= 1'b0;
        send       <= 1'b0;
        edit       <= 1'b0;
        busy       <= 1'b0;
        aborted    <= 1'b1;
      end else
        case (state)
          IDLE:
            if (bus.start) begin
              total      <= {bus.num_lines == '0, bus.num_lines};
              line       <= '0;
              code       <= '0;
              bidx       <= '0;
              edit       <= 1'b1;
              busy       <= 1'b1;
              byte_ready <= 1'b1;
              state      <= COLLECT;
            end
          COLLECT:
            if (bus.byte_valid && byte_ready) begin
              code[8*bidx +: 8] <= bus.byte_in;
              if (bidx == BI_W'(NB - 1)) begin
                byte_ready <= 1'b0;
                state      <= SETUP;
              end else
                bidx <= bidx + BI_W'(1);
            end
          SETUP: begin
            send  <= 1'b1;
            scnt  <= SC_W'(1);
            state <= STROBE;
          end
          STROBE:
            if (scnt == SC_W'(SEND_W)) begin
              send  <= 1'b0;
              state <= HOLD;
            end else
              scnt <= scnt + SC_W'(1);
          HOLD:
            if ({1'b0, line} + (LINE_W+1)'(1) == total) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              line       <= line + LINE_W'(1);
              bidx       <= '0;
              byte_ready <= 1'b1;
              state      <= COLLECT;
            end
          FINISH: begin
            edit  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
    end
endmodule
